// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the LC-3b instruction-fetch stage: machine word,
// fetch state encoding and an address-alignment helper.
package if_fetch_unit_pkg;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      FETCH = 2'b00,
      HOLD  = 2'b01,
      DRAIN = 2'b10
   } lc3b_fetch_state;

   function automatic lc3b_word word_align(input lc3b_word addr);
      return {addr[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/if_fetch_unit_register.sv
// Generic load-enabled register with asynchronous active-high reset,
// used for the fetch PC, redirect target and hold buffer.
module register #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // state update
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= RESET_VAL;
      else if (load)
         q <= d;
      else
         q <= q;
   end

endmodule

// File: rtl/if_fetch_unit.sv
// LC-3b instruction-fetch stage: owns the fetch PC, drives the imem read port
// and feeds the IF/ID latch, inserting bubbles when no instruction is ready.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000,
   parameter lc3b_word NOP_WORD = 16'h0000
) (
   input  logic     clk,
   input  logic     reset,
   output logic     imem_read,
   output lc3b_word imem_address,
   input  logic     imem_resp,
   input  lc3b_word imem_rdata,
   input  logic     stall,
   input  logic     redirect,
   input  lc3b_word redirect_pc,
   output logic     if_id_load,
   output lc3b_word if_id_ir,
   output lc3b_word if_id_pc,
   output logic     if_id_inject_nop
);

   lc3b_fetch_state state, next_state;
   logic            started;

   lc3b_word pc, pc_next, pc_plus2, target, redirect_target;
   lc3b_word hold_ir, hold_pc;
   logic     pc_load, target_load, hold_load;
   logic     hold_valid, hold_valid_load, hold_valid_next;

   assign pc_plus2        = pc + 16'd2;
   assign redirect_target = word_align(redirect_pc);

   register #(.WIDTH(16), .RESET_VAL(RESET_PC)) pc_reg (
      .clk(clk), .reset(reset), .load(pc_load), .d(pc_next), .q(pc));

   register #(.WIDTH(16), .RESET_VAL(16'h0000)) target_reg (
      .clk(clk), .reset(reset), .load(target_load), .d(redirect_target), .q(target));

   register #(.WIDTH(16), .RESET_VAL(16'h0000)) hold_ir_reg (
      .clk(clk), .reset(reset), .load(hold_load), .d(imem_rdata), .q(hold_ir));

   register #(.WIDTH(16), .RESET_VAL(16'h0000)) hold_pc_reg (
      .clk(clk), .reset(reset), .load(hold_load), .d(pc_plus2), .q(hold_pc));

   register #(.WIDTH(1), .RESET_VAL(1'b0)) hold_valid_reg (
      .clk(clk), .reset(reset), .load(hold_valid_load), .d(hold_valid_next), .q(hold_valid));

   // started keeps the read request low until the first edge after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= FETCH;
         started <= 1'b0;
      end else begin
         state   <= next_state;
         started <= 1'b1;
      end
   end

   // next-state, datapath enables and IF/ID outputs
   always_comb begin
      next_state       = state;
      pc_load          = 1'b0;
      pc_next          = pc_plus2;
      target_load      = 1'b0;
      hold_load        = 1'b0;
      hold_valid_load  = 1'b0;
      hold_valid_next  = 1'b0;
      imem_read        = 1'b0;
      imem_address     = pc;
      if_id_load       = 1'b0;
      if_id_ir         = NOP_WORD;
      if_id_pc         = 16'h0000;
      if_id_inject_nop = 1'b1;
      if (started) begin
         if_id_load = ~stall;
         case (state)
            FETCH: begin
               imem_read = 1'b1;
               if (imem_resp) begin
                  pc_load = 1'b1;
                  if (redirect) begin
                     pc_next = redirect_target;
                  end else if (!stall) begin
                     if_id_ir         = imem_rdata;
                     if_id_pc         = pc_plus2;
                     if_id_inject_nop = 1'b0;
                  end else begin
                     hold_load       = 1'b1;
                     hold_valid_load = 1'b1;
                     hold_valid_next = 1'b1;
                     next_state      = HOLD;
                  end
               end else if (redirect) begin
                  target_load = 1'b1;
                  next_state  = DRAIN;
               end else begin
                  next_state = FETCH;
               end
            end
            HOLD: begin
               // a redirect kills the buffered word even when the latch is free
               if (redirect) begin
                  pc_load         = 1'b1;
                  pc_next         = redirect_target;
                  hold_valid_load = 1'b1;
                  next_state      = FETCH;
               end else if (!stall) begin
                  if (hold_valid) begin
                     if_id_ir         = hold_ir;
                     if_id_pc         = hold_pc;
                     if_id_inject_nop = 1'b0;
                  end else begin
                     if_id_inject_nop = 1'b1;
                  end
                  hold_valid_load = 1'b1;
                  next_state      = FETCH;
               end else begin
                  next_state = HOLD;
               end
            end
            DRAIN: begin
               imem_read = 1'b1;
               if (imem_resp) begin
                  pc_load    = 1'b1;
                  pc_next    = redirect ? redirect_target : target;
                  next_state = FETCH;
               end else if (redirect) begin
                  target_load = 1'b1;
               end else begin
                  next_state = DRAIN;
               end
            end
            default: begin
               next_state = FETCH;
            end
         endcase
      end else begin
         if_id_load = 1'b0;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit; the bench plays the role of
// instruction memory by driving imem_resp/imem_rdata per cycle.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_read;
   logic [15:0] imem_address;
   logic        imem_resp;
   logic [15:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        if_id_load;
   logic [15:0] if_id_ir;
   logic [15:0] if_id_pc;
   logic        if_id_inject_nop;

   int checks = 0;
   int errors = 0;

   if_fetch_unit #(.RESET_PC(16'h0000), .NOP_WORD(16'h0000)) dut (
      .clk(clk), .reset(reset),
      .imem_read(imem_read), .imem_address(imem_address),
      .imem_resp(imem_resp), .imem_rdata(imem_rdata),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .if_id_load(if_id_load), .if_id_ir(if_id_ir), .if_id_pc(if_id_pc),
      .if_id_inject_nop(if_id_inject_nop));

   always #5 clk = ~clk;

   typedef struct {
      logic        stall;
      logic        redir;
      logic [15:0] rpc;
      logic        resp;
      logic [15:0] rdata;
      logic        e_read;
      logic [15:0] e_addr;
      logic        e_load;
      logic [15:0] e_ir;
      logic [15:0] e_pc;
      logic        e_nop;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic st, input logic rd, input logic [15:0] rp,
                               input logic rs, input logic [15:0] dt,
                               input logic er, input logic [15:0] ea, input logic el,
                               input logic [15:0] ei, input logic [15:0] ep, input logic en);
      vec_t v;
      v.stall = st; v.redir = rd; v.rpc = rp; v.resp = rs; v.rdata = dt;
      v.e_read = er; v.e_addr = ea; v.e_load = el; v.e_ir = ei; v.e_pc = ep; v.e_nop = en;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input vec_t v);
      check({tag, " imem_read"}, {15'd0, imem_read}, {15'd0, v.e_read});
      if (v.e_read)
         check({tag, " imem_address"}, imem_address, v.e_addr);
      check({tag, " if_id_load"}, {15'd0, if_id_load}, {15'd0, v.e_load});
      if (v.e_load) begin
         check({tag, " if_id_ir"}, if_id_ir, v.e_ir);
         check({tag, " if_id_pc"}, if_id_pc, v.e_pc);
         check({tag, " inject_nop"}, {15'd0, if_id_inject_nop}, {15'd0, v.e_nop});
      end
   endtask

   task automatic drive(input logic st, input logic rd, input logic [15:0] rp,
                        input logic rs, input logic [15:0] dt);
      stall = st; redirect = rd; redirect_pc = rp; imem_resp = rs; imem_rdata = dt;
   endtask

   vec_t rst_v;

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);

      //      st rd rpc       rs rdata     rd addr      ld ir        pc        nop
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
      // 1-cycle memory
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 1, 16'h1111, 16'h0002, 0));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0002, 1, 16'h2222, 16'h0004, 0));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h3333, 1, 16'h0004, 1, 16'h3333, 16'h0006, 0));
      // 3-cycle latency: two bubbles
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h4444, 1, 16'h0006, 1, 16'h4444, 16'h0008, 0));
      // resp under stall, held 4 cycles, delivered once
      vq.push_back(mk(1, 0, 16'h0000, 1, 16'h5555, 1, 16'h0008, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h5555, 16'h000A, 0));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h6666, 1, 16'h000A, 1, 16'h6666, 16'h000C, 0));
      // redirect to 3001 mid-request: drain, stale word dropped
      vq.push_back(mk(0, 1, 16'h3001, 0, 16'h0000, 1, 16'h000C, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h000C, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h7777, 1, 16'h000C, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h8888, 1, 16'h3000, 1, 16'h8888, 16'h3002, 0));
      // redirect coincident with resp in FETCH
      vq.push_back(mk(0, 1, 16'h4000, 1, 16'h9999, 1, 16'h3002, 1, 16'h0000, 16'h0000, 1));
      // redirect in HOLD while still stalled
      vq.push_back(mk(1, 0, 16'h0000, 1, 16'hAAAA, 1, 16'h4000, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(1, 1, 16'h5000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h5000, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'hBBBB, 1, 16'h5000, 1, 16'hBBBB, 16'h5002, 0));
      // redirect in HOLD as stall releases: bubble, not the buffer
      vq.push_back(mk(1, 0, 16'h0000, 1, 16'hCCCC, 1, 16'h5002, 0, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 1, 16'h6000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'hDDDD, 1, 16'h6000, 1, 16'hDDDD, 16'h6002, 0));
      // DRAIN: later redirect overwrites target, coincident redirect wins
      vq.push_back(mk(0, 1, 16'h7000, 0, 16'h0000, 1, 16'h6002, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 1, 16'h7100, 0, 16'h0000, 1, 16'h6002, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 1, 16'h7200, 1, 16'hEEEE, 1, 16'h6002, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h1234, 1, 16'h7200, 1, 16'h1234, 16'h7202, 0));
      // wrap at FFFE (reached through an odd redirect target)
      vq.push_back(mk(0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h7202, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h0000, 1, 16'h7202, 1, 16'h0000, 16'h0000, 1));
      vq.push_back(mk(0, 0, 16'h0000, 1, 16'h5A5A, 1, 16'hFFFE, 1, 16'h5A5A, 16'h0000, 0));
      vq.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 16'h0000, 16'h0000, 1));

      rst_v = mk(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);

      #12;
      check("reset imem_read", {15'd0, imem_read}, 16'h0000);
      check("reset if_id_load", {15'd0, if_id_load}, 16'h0000);
      check("reset if_id_ir", if_id_ir, 16'h0000);
      check("reset if_id_pc", if_id_pc, 16'h0000);
      check("reset inject_nop", {15'd0, if_id_inject_nop}, 16'h0001);

      @(posedge clk);
      #2 reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge clk);
         drive(vq[i].stall, vq[i].redir, vq[i].rpc, vq[i].resp, vq[i].rdata);
         #1;
         check_outputs($sformatf("vec%0d", i), vq[i]);
      end

      // reset asserted while draining a request
      @(negedge clk);
      drive(1'b0, 1'b1, 16'h0100, 1'b0, 16'h0000);
      #1 check("pre-drain addr", imem_address, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
      #1 check("drain imem_read", {15'd0, imem_read}, 16'h0001);
      check("drain addr", imem_address, 16'h0000);
      reset = 1'b1;
      #1;
      check_outputs("drain-reset", rst_v);
      check("drain-reset ir", if_id_ir, 16'h0000);
      check("drain-reset nop", {15'd0, if_id_inject_nop}, 16'h0001);
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      #1 check("post-reset idle read", {15'd0, imem_read}, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1357);
      #1 check("post-reset addr", imem_address, 16'h0000);
      check("post-reset read", {15'd0, imem_read}, 16'h0001);
      check("post-reset ir", if_id_ir, 16'h1357);
      check("post-reset pc", if_id_pc, 16'h0002);
      check("post-reset nop", {15'd0, if_id_inject_nop}, 16'h0000);
      @(negedge clk);
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
